// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer: FETCH/DECODE/EXEC/MEM/WB with mem_ready stalls.
// Outputs are combinational decodes of the registered state; instr_count counts retired instructions.
module mc_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic [4:0]  phase,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_cond_we,
    output logic        a_we,
    output logic        b_we,
    output logic        ao_we,
    output logic        mdr_we,
    output logic        gr_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [5:0]  alu_func,
    output logic        retire,
    output logic        halted,
    output logic [31:0] instr_count
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr_count;
    logic        w_legal;

    assign w_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ) || (opcode == OP_ADDI);
    assign instr_count = r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (retire)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        phase      = '0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_cond_we = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        ao_we      = 1'b0;
        mdr_we     = 1'b0;
        gr_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        pc_src     = 2'd0;
        alu_func   = 6'b000000;
        retire     = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                phase     = 5'b00001;
                mem_rd    = 1'b1;
                alu_src_b = 2'd1;
                alu_func  = ALU_ADD;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut while operands latch.
                phase     = 5'b00010;
                a_we      = 1'b1;
                b_we      = 1'b1;
                ao_we     = 1'b1;
                alu_src_b = 2'd3;
                alu_func  = ALU_ADD;
                if (opcode == OP_J) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    retire = 1'b1;
                end else if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_EXEC: begin
                phase     = 5'b00100;
                alu_src_a = 1'b1;
                case (opcode)
                    OP_R: begin
                        alu_func = funct;
                        ao_we    = 1'b1;
                        w_next   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'd2;
                        alu_func  = ALU_ADD;
                        ao_we     = 1'b1;
                        w_next    = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_src_b = 2'd2;
                        alu_func  = ALU_ADD;
                        ao_we     = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_BEQ: begin
                        alu_func   = ALU_SUB;
                        pc_cond_we = 1'b1;
                        pc_src     = 2'd1;
                        retire     = 1'b1;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                phase = 5'b01000;
                iord  = 1'b1;
                if (opcode == OP_LW) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        mdr_we = 1'b1;
                        w_next = S_WB;
                    end
                end else begin
                    mem_wr = 1'b1;
                    if (mem_ready)
                        retire = 1'b1;
                end
            end
            S_WB: begin
                phase      = 5'b10000;
                gr_we      = 1'b1;
                reg_dst    = (opcode == OP_R);
                mem_to_reg = (opcode == OP_LW);
                retire     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (retire)
            w_next = run ? S_FETCH : S_IDLE;
        // Reset silences every side effect even while the old state is still registered.
        if (reset) begin
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_cond_we = 1'b0;
            a_we       = 1'b0;
            b_we       = 1'b0;
            ao_we      = 1'b0;
            mdr_we     = 1'b0;
            gr_we      = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            retire     = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level sequence model feeding a per-cycle expectation queue.
module tb_mc_control_fsm;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int P_IDLE = 0, P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5, P_HALT = 6;

    logic clk = 1'b0;
    logic reset, run, mem_ready;
    logic [5:0] opcode, funct;
    logic [4:0] phase;
    logic ir_we, pc_we, pc_cond_we, a_we, b_we, ao_we, mdr_we, gr_we;
    logic mem_rd, mem_wr, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [5:0] alu_func;
    logic retire, halted;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .phase(phase), .ir_we(ir_we), .pc_we(pc_we),
        .pc_cond_we(pc_cond_we), .a_we(a_we), .b_we(b_we), .ao_we(ao_we),
        .mdr_we(mdr_we), .gr_we(gr_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_func(alu_func), .retire(retire), .halted(halted),
        .instr_count(instr_count)
    );

    // en = {ir, pc, pc_cond, a, b, ao, mdr, gr}
    typedef struct packed {
        logic [4:0]  phase;
        logic [7:0]  en;
        logic        rd, wr, iord, reg_dst, m2r, src_a;
        logic [1:0]  src_b, pc_src;
        logic [5:0]  func;
        logic        retire, halted;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        vec_t v;
        bit   care_all;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        obs_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_count = '0;

    function automatic vec_t sample();
        vec_t s;
        s.phase   = phase;
        s.en      = {ir_we, pc_we, pc_cond_we, a_we, b_we, ao_we, mdr_we, gr_we};
        s.rd      = mem_rd;
        s.wr      = mem_wr;
        s.iord    = iord;
        s.reg_dst = reg_dst;
        s.m2r     = mem_to_reg;
        s.src_a   = alu_src_a;
        s.src_b   = alu_src_b;
        s.pc_src  = pc_src;
        s.func    = alu_func;
        s.retire  = retire;
        s.halted  = halted;
        s.cnt     = instr_count;
        return s;
    endfunction

    function automatic vec_t strobe_mask();
        vec_t m;
        m        = '0;
        m.en     = '1;
        m.rd     = 1'b1;
        m.wr     = 1'b1;
        m.retire = 1'b1;
        return m;
    endfunction

    // What the control word must be in a given instruction step.
    function automatic exp_t model(int ph, logic [5:0] op, logic [5:0] fn, logic rdy, logic rst);
        exp_t e;
        e.v        = '0;
        e.care_all = !rst;
        e.v.cnt    = m_count;
        if (rst) return e;
        case (ph)
            P_F: begin
                e.v.phase = 5'b00001; e.v.rd = 1'b1; e.v.src_b = 2'd1; e.v.func = 6'b100000;
                e.v.en[7] = rdy; e.v.en[6] = rdy;
            end
            P_D: begin
                e.v.phase = 5'b00010; e.v.en[4] = 1'b1; e.v.en[3] = 1'b1; e.v.en[2] = 1'b1;
                e.v.src_b = 2'd3; e.v.func = 6'b100000;
                if (op == OP_J) begin
                    e.v.en[6] = 1'b1; e.v.pc_src = 2'd2; e.v.retire = 1'b1;
                end
            end
            P_E: begin
                e.v.phase = 5'b00100; e.v.src_a = 1'b1;
                if (op == OP_BEQ) begin
                    e.v.func = 6'b100010; e.v.en[5] = 1'b1; e.v.pc_src = 2'd1; e.v.retire = 1'b1;
                end else begin
                    e.v.en[2] = 1'b1;
                    e.v.func  = (op == OP_R) ? fn : 6'b100000;
                    e.v.src_b = (op == OP_R) ? 2'd0 : 2'd2;
                end
            end
            P_M: begin
                e.v.phase = 5'b01000; e.v.iord = 1'b1;
                if (op == OP_LW) begin
                    e.v.rd = 1'b1; e.v.en[1] = rdy;
                end else begin
                    e.v.wr = 1'b1; e.v.retire = rdy;
                end
            end
            P_W: begin
                e.v.phase = 5'b10000; e.v.en[0] = 1'b1; e.v.retire = 1'b1;
                e.v.reg_dst = (op == OP_R); e.v.m2r = (op == OP_LW);
            end
            P_HALT: e.v.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : compare
        vec_t a;
        vec_t mk;
        exp_t e;
        a = sample();
        obs_q.push_back(a);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            mk = e.care_all ? '1 : strobe_mask();
            n_cmp++;
            if ((a & mk) !== (e.v & mk)) begin
                n_bad++;
                $display("FAIL cycle_vec t=%0t got=%h want=%h mask=%h", $time, a, e.v, mk);
            end
            n_cmp++;
            if (!$onehot0(a.phase) || (a.rd && a.wr)) begin
                n_bad++;
                $display("FAIL exclusivity t=%0t phase=%b rd=%b wr=%b", $time, a.phase, a.rd, a.wr);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic step(int ph, logic [5:0] op, logic [5:0] fn, logic rdy, logic rv, logic rst);
        exp_t e;
        reset = rst; run = rv; opcode = op; funct = fn; mem_ready = rdy;
        e = model(ph, op, fn, rdy, rst);
        exp_q.push_back(e);
        if (rst) m_count = '0;
        else if (e.v.retire) m_count = m_count + 32'd1;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH entry; wf/wm are mem_ready-low cycles in FETCH/MEM.
    task automatic instr(logic [5:0] op, logic [5:0] fn, int wf, int wm, logic rl);
        int seq[$];
        case (op)
            OP_R, OP_ADDI: seq = {P_F, P_D, P_E, P_W};
            OP_LW:         seq = {P_F, P_D, P_E, P_M, P_W};
            OP_SW:         seq = {P_F, P_D, P_E, P_M};
            OP_BEQ:        seq = {P_F, P_D, P_E};
            default:       seq = {P_F, P_D};
        endcase
        foreach (seq[i]) begin
            if (seq[i] == P_F) begin
                repeat (wf) step(P_F, OP_BAD, fn, 1'b0, rl, 1'b0);
                step(P_F, OP_BAD, fn, 1'b1, rl, 1'b0);
            end else if (seq[i] == P_M) begin
                repeat (wm) step(P_M, op, fn, 1'b0, rl, 1'b0);
                step(P_M, op, fn, 1'b1, rl, 1'b0);
            end else begin
                step(seq[i], op, fn, 1'($urandom_range(0, 1)), rl, 1'b0);
            end
        end
    endtask

    initial begin
        logic [4:0] lw_phases [5];
        int nwr, nret, ngr;
        lw_phases = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        reset = 1'b1; run = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(P_IDLE, OP_R, 6'd0, 1'b1, 1'b1, 1'b1);
        step(P_IDLE, OP_R, 6'd0, 1'b1, 1'b1, 1'b1);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0);
        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0);
        step(P_IDLE, OP_BAD, 6'd0, 1'b0, 1'b1, 1'b0);

        obs_q.delete();
        instr(OP_LW, 6'd0, 0, 0, 1'b1);
        chk("lw_len", obs_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk("lw_phase", {27'd0, obs_q[i].phase}, {27'd0, lw_phases[i]});
        chk("lw_mdr_we", {31'd0, obs_q[3].en[1]}, 32'd1);
        chk("lw_gr_m2r", {30'd0, obs_q[4].en[0], obs_q[4].m2r}, 32'd3);
        chk("lw_count", instr_count, 32'd1);

        obs_q.delete();
        instr(OP_R, 6'b100010, 0, 0, 1'b1);
        chk("r_len", obs_q.size(), 32'd4);
        chk("r_alu_func", {26'd0, obs_q[2].func}, 32'h22);
        chk("r_reg_dst", {31'd0, obs_q[3].reg_dst}, 32'd1);
        chk("r_retire", {31'd0, obs_q[3].retire}, 32'd1);

        obs_q.delete();
        instr(OP_ADDI, 6'd0, 2, 0, 1'b1);
        chk("addi_len", obs_q.size(), 32'd6);
        chk("addi_wb", {30'd0, obs_q[5].reg_dst, obs_q[5].en[0]}, 32'd1);

        obs_q.delete();
        instr(OP_SW, 6'd0, 0, 3, 1'b1);
        nwr = 0; nret = 0; ngr = 0;
        foreach (obs_q[i]) begin
            nwr  += int'(obs_q[i].wr);
            nret += int'(obs_q[i].retire);
            ngr  += int'(obs_q[i].en[0]);
        end
        chk("sw_mem_wr_cycles", nwr, 32'd4);
        chk("sw_retires", nret, 32'd1);
        chk("sw_gr_we", ngr, 32'd0);

        obs_q.delete();
        instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0);
        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("beq_pc_cond_we", {31'd0, obs_q[2].en[5]}, 32'd1);
        chk("beq_then_idle", {27'd0, obs_q[3].phase}, 32'd0);

        obs_q.delete();
        instr(OP_J, 6'd0, 0, 0, 1'b1);
        chk("j_len", obs_q.size(), 32'd2);
        chk("j_pc_src", {30'd0, obs_q[1].pc_src}, 32'd2);
        chk("count_after_six", instr_count, 32'd6);

        obs_q.delete();
        step(P_F, OP_BAD, 6'd0, 1'b1, 1'b1, 1'b0);
        step(P_D, OP_LW, 6'd0, 1'b1, 1'b1, 1'b0);
        step(P_E, OP_LW, 6'd0, 1'b1, 1'b1, 1'b0);
        step(P_M, OP_LW, 6'd0, 1'b0, 1'b1, 1'b0);
        step(P_M, OP_LW, 6'd0, 1'b1, 1'b1, 1'b1);
        step(P_IDLE, OP_LW, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_count", instr_count, 32'd0);
        ngr = 0;
        foreach (obs_q[i]) ngr += int'(obs_q[i].en[0]);
        chk("rst_mid_gr_we", ngr, 32'd0);
        chk("rst_mid_idle", {27'd0, obs_q[5].phase}, 32'd0);

        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b1, 1'b0);
        instr(OP_BAD, 6'd0, 0, 0, 1'b1);
        repeat (10) step(P_HALT, OP_BAD, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_phase", {27'd0, phase}, 32'd0);
        step(P_HALT, OP_BAD, 6'd0, 1'b1, 1'b1, 1'b1);
        step(P_IDLE, OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("halt_cleared", {31'd0, halted}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock.
REQ-002 SHALL have: reset input 1, synchronous, active-high.
REQ-003 SHALL have: run input 1, permits a new instruction to start from FETCH.
REQ-004 SHALL have: opcode input 6, IR[31:26], valid from DECODE onward.
REQ-005 SHALL have: funct input 6, IR[5:0].
REQ-006 SHALL have: mem_ready input 1, memory access completes this cycle.
REQ-007 SHALL have: phase output 5, one-hot {WB,MEM,EXEC,DECODE,FETCH} = bits 4..0; all-zero in IDLE/HALT.
REQ-008 SHALL have latch enables, output 1 each: ir_we, pc_we, pc_cond_we, a_we, b_we, ao_we, mdr_we, gr_we.
REQ-009 SHALL have: mem_rd, mem_wr output 1; iord output 1 (0=PC address, 1=ALUOut address).
REQ-010 SHALL have selects: reg_dst output 1 (0=rt, 1=rd); mem_to_reg output 1 (0=ALUOut, 1=MDR); alu_src_a output 1 (0=PC, 1=A); alu_src_b output 2 (0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2); pc_src output 2 (0=ALU result, 1=ALUOut, 2=jump target).
REQ-011 SHALL have: alu_func output 6; retire output 1; halted output 1; instr_count output 32.

Function
REQ-012 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs are combinational decodes of the registered state plus opcode/funct; no output depends on run or mem_ready except as stated.
REQ-013 IDLE: run=1 -> FETCH next cycle; run=0 -> stay.
REQ-014 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, alu_func=100000; while mem_ready=0, hold with all enables 0; on mem_ready=1, assert ir_we=1 and pc_we=1 (pc_src=0) for that cycle -> DECODE.
REQ-015 DECODE: a_we=b_we=1, ao_we=1, alu_src_a=0, alu_src_b=3, alu_func=100000 (branch target); opcode j (000010) -> pc_we=1, pc_src=2, retire -> FETCH/IDLE per REQ-022; legal others -> EXEC; illegal -> HALT.
REQ-016 Legal opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi; anything else is illegal.
REQ-017 EXEC R-type: alu_src_a=1, alu_src_b=0, alu_func=funct, ao_we=1 -> WB.
REQ-018 EXEC lw/sw/addi: alu_src_a=1, alu_src_b=2, alu_func=100000, ao_we=1; lw/sw -> MEM, addi -> WB.
REQ-019 EXEC beq: alu_src_a=1, alu_src_b=0, alu_func=100010, pc_cond_we=1, pc_src=1; retire -> FETCH/IDLE.
REQ-020 MEM: iord=1; lw: mem_rd=1, mdr_we=1 on the mem_ready cycle -> WB; sw: mem_wr=1, retire on the mem_ready cycle -> FETCH/IDLE; mem_ready=0 holds the state with mdr_we=0 and mem_rd/mem_wr kept asserted.
REQ-021 WB: gr_we=1 for exactly one cycle; R-type reg_dst=1, mem_to_reg=0; addi reg_dst=0, mem_to_reg=0; lw reg_dst=0, mem_to_reg=1; retire.
REQ-022 On a retire cycle: next state is FETCH if run=1, else IDLE; instr_count increments by 1, wrapping 0xFFFFFFFF -> 0.
REQ-023 Cycle counts from FETCH entry, with mem_ready=1: j 2, beq 3, R-type/addi/sw 4, lw 5.
REQ-024 HALT: halted=1, all enables and mem strobes 0, phase=0; exit only via reset.
REQ-025 Unused select outputs in any state SHALL be driven 0; alu_func SHALL default to 000000.
REQ-026 At most one of mem_rd/mem_wr SHALL be 1 in any cycle; at most one phase bit SHALL be 1.

Reset
REQ-027 reset=1 at a clock edge -> state IDLE, instr_count=0, halted=0, regardless of state, including mid-instruction or a pending mem_ready wait; reset dominates run.
REQ-028 While in reset and in the cycle after, all enables and mem strobes SHALL be 0.

Verification
REQ-029 run=1, lw, mem_ready=1 -> phase 00001,00010,00100,01000,10000; mdr_we in MEM; gr_we with mem_to_reg=1; instr_count=1.
REQ-030 R-type funct=100010 -> EXEC alu_func=100010; WB reg_dst=1; retire after 4 cycles.
REQ-031 sw with mem_ready low 3 cycles in MEM -> mem_wr held 4 cycles, single retire, no gr_we.
REQ-032 opcode 111111 -> HALT, halted=1, phase=00000 persists 10 cycles; reset -> IDLE, halted=0.
REQ-033 beq, then run=0 -> pc_cond_we=1 in EXEC, then IDLE; run=1 -> FETCH.
REQ-034 reset asserted in MEM of lw -> next cycle IDLE, instr_count=0, no gr_we.
